// File: rtl/m_sync_pkg.sv
// -----------------------------------------------------------------------------
// m_sync_pkg
// Shared definitions for the M-sequence synchronizer:
//   - m_state_e      : acquisition / tracking FSM states
//   - M_WIN          : correlation window length (one full M-sequence period)
//   - M_DEFAULT_SEED : substitute seed used when an all-zero seed is supplied
//   - m_lfsr_next    : next state of the x^5+x^2+1 generator
//   - m_seed_fix     : maps the forbidden all-zero seed to M_DEFAULT_SEED
// -----------------------------------------------------------------------------
package m_sync_pkg;

  localparam int         M_WIN          = 31;
  localparam logic [4:0] M_DEFAULT_SEED = 5'b10101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CORR = 3'd1,
    ST_SLIP = 3'd2,
    ST_LOCK = 3'd3,
    ST_FAIL = 3'd4
  } m_state_e;

  // Fibonacci form of x^5+x^2+1: feedback s[0]^s[2] enters at the top bit,
  // the register shifts down, and the output chip is s[0].
  function automatic logic [4:0] m_lfsr_next(input logic [4:0] s);
    return {s[0] ^ s[2], s[4:1]};
  endfunction

  // The all-zero state is a lock-up state of the generator, so it is never
  // allowed to be loaded.
  function automatic logic [4:0] m_seed_fix(input logic [4:0] seed);
    return (seed == 5'b00000) ? M_DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/m_lfsr5.sv
// -----------------------------------------------------------------------------
// m_lfsr5
// Seeded 5-bit M-code generator (x^5+x^2+1, period 31).
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset (state returns to 5'b00000)
//   load     in   load seed (all-zero seed replaced by M_DEFAULT_SEED)
//   advance  in   step the generator by one chip (ignored while load is high)
//   seed     in   5-bit seed value
//   chip     out  current output chip (state bit 0)
// With load and advance both low the generator holds its phase.
// -----------------------------------------------------------------------------
module m_lfsr5
  import m_sync_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       advance,
  input  logic [4:0] seed,
  output logic       chip
);

  logic [4:0] lfsr_q;
  logic [4:0] lfsr_d;

  always_comb begin
    // NOTE: every always_comb output is given a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = m_seed_fix(seed);
    end else if (advance) begin
      lfsr_d = m_lfsr_next(lfsr_q);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 5'b00000;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign chip = lfsr_q[0];

endmodule

// File: rtl/m_sync_ctrl.sv
// -----------------------------------------------------------------------------
// m_sync_ctrl
// Acquisition and tracking controller for the M-sequence synchronizer.
// Correlates the received chip stream against a local 5-bit M-code one
// 31-chip window at a time, slipping the local phase by one chip after each
// failed window until lock (>= THRESH agreements) or all 31 phases fail.
//
// Parameters:
//   THRESH       agreements per window needed for lock (16..31)
//   LOSS_THRESH  in LOCK, a window scoring below this is a miss
//   MISS_MAX     consecutive misses that drop lock (>= 1)
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   one-cycle pulse: load seed, restart acquisition (any state)
//   tx_seed     in   initial local M-code state (0 is replaced by 5'b10101)
//   rx_chip     in   received chip
//   chip_valid  in   qualifies rx_chip; one chip consumed per valid cycle
//   sync_flag   out  high while locked
//   busy        out  high while correlating, slipping or locked
//   fail        out  high after all phases were rejected
//   slip_cnt    out  slips performed since start
//   corr_cnt    out  agreement count of the last completed window
//   local_chip  out  current local chip
//
// Build option: define M_SYNC_TRACK_EN to enable loss-of-lock monitoring in
// LOCK. Without it LOCK is held until start or reset and the miss counter is
// not built.
// -----------------------------------------------------------------------------
module m_sync_ctrl
  import m_sync_pkg::*;
#(
  parameter int THRESH      = 28,
  parameter int LOSS_THRESH = 20,
  parameter int MISS_MAX    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [4:0] tx_seed,
  input  logic       rx_chip,
  input  logic       chip_valid,
  output logic       sync_flag,
  output logic       busy,
  output logic       fail,
  output logic [4:0] slip_cnt,
  output logic [5:0] corr_cnt,
  output logic       local_chip
);

  // Elaboration-time guard against nonsensical configurations.
  if (THRESH < 16 || THRESH > M_WIN || LOSS_THRESH < 0 || LOSS_THRESH > M_WIN ||
      MISS_MAX < 1) begin : g_bad_cfg
    $error("m_sync_ctrl: parameter out of range");
  end

  localparam logic [5:0] THRESH_C = 6'(THRESH);
  // Index of the last chip in a window; also the slip count at which every
  // phase has been tried once.
  localparam logic [4:0] LAST_IDX = 5'(M_WIN - 1);

  m_state_e   state_q, state_d;
  logic [4:0] win_q,   win_d;
  logic [5:0] agr_q,   agr_d;
  logic [4:0] slip_q,  slip_d;
  logic [5:0] corr_q,  corr_d;

  logic       lfsr_adv;
  logic       lfsr_chip;
  logic       chip_match;
  logic       win_last;
  logic [5:0] agr_next;

`ifdef M_SYNC_TRACK_EN
  localparam logic [5:0] LOSS_C = 6'(LOSS_THRESH);
  localparam int         MISS_W = (MISS_MAX > 1) ? $clog2(MISS_MAX + 1) : 1;
  localparam logic [MISS_W-1:0] MISS_C = MISS_W'(MISS_MAX);

  // miss_q never exceeds MISS_MAX-1, so miss_next always fits in MISS_W bits.
  logic [MISS_W-1:0] miss_q, miss_d, miss_next;
  assign miss_next = miss_q + 1'b1;
`endif

  // Local generator: loaded by start, stepped only on chips consumed while
  // correlating; the chip swallowed in SLIP leaves it holding.
  m_lfsr5 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start),
    .advance (lfsr_adv),
    .seed    (tx_seed),
    .chip    (lfsr_chip)
  );

  assign chip_match = rx_chip ~^ lfsr_chip;
  assign agr_next   = agr_q + {5'd0, chip_match};
  assign win_last   = (win_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    agr_d    = agr_q;
    slip_d   = slip_q;
    corr_d   = corr_q;
    lfsr_adv = 1'b0;
`ifdef M_SYNC_TRACK_EN
    miss_d   = miss_q;
`endif

    if (start) begin
      // Restart wins over a simultaneous chip; that chip is not counted.
      state_d = ST_CORR;
      win_d   = '0;
      agr_d   = '0;
      slip_d  = '0;
`ifdef M_SYNC_TRACK_EN
      miss_d  = '0;
`endif
    end else if (chip_valid) begin
      case (state_q)
        ST_CORR, ST_LOCK: begin
          lfsr_adv = 1'b1;
          if (win_last) begin
            // Window complete: publish the score (including this chip) and
            // rearm the window counters for the next window.
            win_d  = '0;
            agr_d  = '0;
            corr_d = agr_next;
            if (state_q == ST_CORR) begin
              if (agr_next >= THRESH_C) begin
                state_d = ST_LOCK;
              end else if (slip_q == LAST_IDX) begin
                state_d = ST_FAIL;
              end else begin
                state_d = ST_SLIP;
              end
            end
`ifdef M_SYNC_TRACK_EN
            else if (agr_next < LOSS_C) begin
              if (miss_next >= MISS_C) begin
                // Drop lock but keep the generator phase: reacquisition
                // starts from where tracking was lost.
                state_d = ST_CORR;
                slip_d  = '0;
                miss_d  = '0;
              end else begin
                miss_d = miss_next;
              end
            end else begin
              miss_d = '0;
            end
`endif
          end else begin
            win_d = win_q + 5'd1;
            agr_d = agr_next;
          end
        end

        ST_SLIP: begin
          slip_d  = slip_q + 5'd1;
          state_d = ST_CORR;
        end

        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      agr_q   <= '0;
      slip_q  <= '0;
      corr_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      agr_q   <= agr_d;
      slip_q  <= slip_d;
      corr_q  <= corr_d;
    end
  end

`ifdef M_SYNC_TRACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_q <= '0;
    end else begin
      miss_q <= miss_d;
    end
  end
`endif

  // All outputs decode registered state only.
  assign sync_flag  = (state_q == ST_LOCK);
  assign busy       = (state_q == ST_CORR) || (state_q == ST_SLIP) ||
                      (state_q == ST_LOCK);
  assign fail       = (state_q == ST_FAIL);
  assign slip_cnt   = slip_q;
  assign corr_cnt   = corr_q;
  assign local_chip = lfsr_chip;

endmodule

// File: doc/m_sync_ctrl.md
# m_sync_ctrl

Acquisition and tracking controller for the M-sequence synchronizer. It holds the local 5-bit M-code generator and compares it against the received chip stream one window at a time. After each failed window it slips the local phase by one chip, until correlation passes a threshold (lock) or all 31 phases are exhausted (fail). It sits between the receive chip source and the downstream data path, and drives `sync_flag` for the rest of the design.

## Interface
- `THRESH`, 28: agreements per 31-chip window required to declare lock (range 16..31).
- `LOSS_THRESH`, 20: in LOCK, a window with fewer agreements than this counts as a miss.
- `MISS_MAX`, 2: number of consecutive missed windows that drops lock.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse that loads the seed and begins acquisition; accepted in any state.
- `tx_seed`  in  5  initial local M-code state; 5'b00000 is replaced by 5'b10101.
- `rx_chip`  in  1  received chip.
- `chip_valid`  in  1  qualifies `rx_chip`; one chip is consumed per cycle in which it is high.
- `sync_flag`  out  1  high while in LOCK.
- `busy`  out  1  high in CORR, SLIP or LOCK.
- `fail`  out  1  high in FAIL.
- `slip_cnt`  out  5  slips performed since `start`.
- `corr_cnt`  out  6  agreement count of the last completed window.
- `local_chip`  out  1  current local chip (state bit 0).

## Operation
- **Local generator (LFSR).** Polynomial x^5+x^2+1.
  - Next state = {s[0]^s[2], s[4:1]}; output chip = s[0]; period 31.
  - Advances only on a consumed chip in CORR or LOCK.
- **States.** IDLE, CORR, SLIP, LOCK, FAIL.
- **IDLE / FAIL, on `start`.**
  - Load seed; clear `slip_cnt`, window counter, agreement counter and miss counter.
  - Go to CORR.
- **CORR, on each valid chip.**
  - Agreement counter += (`rx_chip` == `local_chip`); window counter +1.
  - On the 31st chip, `corr_cnt` takes the final count (including this chip).
  - If count ≥ `THRESH` → LOCK.
  - Else if `slip_cnt` == 30 → FAIL.
  - Else → SLIP.
- **SLIP.** Waits for one valid chip. That chip is discarded and the LFSR holds, which delays the local phase by one chip. `slip_cnt` +1; → CORR.
- **LOCK.** Windows continue as in CORR. A window scoring below `LOSS_THRESH` increments the miss counter; any other window clears it. When misses reach `MISS_MAX`, go to CORR with `slip_cnt`, window and agreement counters cleared; the LFSR phase is kept.
- **`start` in CORR, SLIP or LOCK.** Same effect as `start` in IDLE (full restart).
- **Simultaneous `start` and `chip_valid`.** `start` wins; that chip is not counted.
- **Counter widths.** The agreement counter is 6 bits and saturates by construction (max 31). The window counter is 5 bits, values 0..30, and wraps to 0 after the 31st chip.

## Timing
- **Reset values.** All outputs are 0. State IDLE, LFSR 5'b00000, all counters 0.
- **Registered outputs.** All outputs are registered state/counter decodes with no combinational input-to-output path.
- **Lock latency.** `sync_flag` rises on the cycle after the clock edge that samples the 31st valid chip of a passing window.
- **Chip stalls.** Gaps in `chip_valid` stall every counter and the LFSR.
- **Reset mid-operation.** Asserting `reset_n` low returns the block to its reset values immediately, independent of `clk`.

## Configuration
- **`M_SYNC_TRACK_EN` defined.** LOCK-state loss monitoring operates as described above.
- **`M_SYNC_TRACK_EN` undefined.** LOCK is sticky until `start` or reset. `corr_cnt` still updates every window. The miss counter logic is not synthesized.

## Structure
- **Package `m_sync_pkg`** holds:
  - the state enum;
  - `M_WIN = 31`;
  - `M_DEFAULT_SEED = 5'b10101`;
  - the LFSR next-state function.
- **Sub-module `m_lfsr5`** contains the seeded 5-bit generator with load, advance and hold controls. The FSM and correlator counters live in `m_sync_ctrl`.

## Test plan
- **Zero offset.** Seed 5'b10101; `rx_chip` is the same sequence, continuous valid. Expect `sync_flag` = 1 one cycle after chip 31, `slip_cnt` = 0, `corr_cnt` = 31.
- **Delay 3.** `rx_chip` is the sequence delayed by 3 chips. Expect lock after 4 windows plus 3 slip chips (127 valid chips), `slip_cnt` = 3, `corr_cnt` = 31.
- **All-zero rx.** Every window scores 15. Expect `fail` = 1 after 991 valid chips, `slip_cnt` = 30, `busy` = 0.
- **Error tolerance.** Aligned stream with 3 inverted chips → lock with `corr_cnt` = 28. With 4 inverted chips → no lock on that window, `slip_cnt` = 1.
- **Tracking.** After lock (with `M_SYNC_TRACK_EN`), invert the stream for 2 windows. Expect `sync_flag` to fall after the second window and `slip_cnt` = 0. Without the macro, `sync_flag` stays 1.
- **Reset and restart.** `reset_n` low mid-CORR → all outputs 0 immediately. `start` asserted in LOCK → `sync_flag` low the next cycle and the seed is reloaded.
